// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline boundary: LANES writeback lanes behind a valid/ready handshake
// with a 2-entry skid buffer, synchronous flush and capture-time enable filtering.
module mem_wb_pipe_reg #(
  parameter int DATA_W           = 64,
  parameter int ADDR_W           = 5,
  parameter int LANES            = 1,
  parameter bit ZERO_REG_GUARD   = 1'b1,
  parameter bit SAME_DEST_SQUASH = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Flush,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [LANES*DATA_W-1:0] RdWriteDataIn,
  input  logic [LANES*ADDR_W-1:0] RdAddrIn,
  input  logic [LANES-1:0]        RdWriteEnableIn,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [LANES*DATA_W-1:0] RdWriteDataOut,
  output logic [LANES*ADDR_W-1:0] RdAddrOut,
  output logic [LANES-1:0]        RdWriteEnableOut,
  output logic [1:0]              Occupancy
);

  // State bits are {main valid, skid valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t                    state_q, state_d;
  logic [LANES*DATA_W-1:0]   main_data_q, main_data_d;
  logic [LANES*ADDR_W-1:0]   main_addr_q, main_addr_d;
  logic [LANES-1:0]          main_en_q, main_en_d;
  logic [LANES*DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [LANES*ADDR_W-1:0]   skid_addr_q, skid_addr_d;
  logic [LANES-1:0]          skid_en_q, skid_en_d;

  logic                      mv, sv;
  logic                      accept, drain;
  logic [LANES-1:0]          in_en_filt;

  // An older lane loses its write when a younger lane writes the same register.
  function automatic logic [LANES-1:0] filter_en(
    input logic [LANES*ADDR_W-1:0] addr,
    input logic [LANES-1:0]        en
  );
    logic [LANES-1:0] guarded;
    logic [LANES-1:0] result;
    guarded = en;
    for (int i = 0; i < LANES; i++) begin
      if (ZERO_REG_GUARD && (addr[i*ADDR_W +: ADDR_W] == '0)) guarded[i] = 1'b0;
    end
    result = guarded;
    if (SAME_DEST_SQUASH) begin
      for (int i = 0; i < LANES; i++) begin
        for (int j = 0; j < LANES; j++) begin
          if ((j > i) && guarded[j] && (addr[j*ADDR_W +: ADDR_W] != '0) &&
              (addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W]))
            result[i] = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign mv         = state_q[1];
  assign sv         = state_q[0];
  assign InReady    = !sv;
  assign OutValid   = mv;
  assign accept     = InValid & InReady;
  assign drain      = OutValid & OutReady;
  assign in_en_filt = filter_en(RdAddrIn, RdWriteEnableIn);

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_addr_d = main_addr_q;
    main_en_d   = main_en_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    skid_en_d   = skid_en_q;
    if (Flush) begin
      state_d   = EMPTY;
      main_en_d = '0;
      skid_en_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = BUSY;
            main_data_d = RdWriteDataIn;
            main_addr_d = RdAddrIn;
            main_en_d   = in_en_filt;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_data_d = RdWriteDataIn;
            main_addr_d = RdAddrIn;
            main_en_d   = in_en_filt;
          end else if (accept) begin
            state_d     = FULL;
            skid_data_d = RdWriteDataIn;
            skid_addr_d = RdAddrIn;
            skid_en_d   = in_en_filt;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d     = BUSY;
            main_data_d = skid_data_q;
            main_addr_d = skid_addr_q;
            main_en_d   = skid_en_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- capture boundary: MEM side -> held entries ----
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_addr_q <= '0;
      main_en_q   <= '0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
      skid_en_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_addr_q <= main_addr_d;
      main_en_q   <= main_en_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      skid_en_q   <= skid_en_d;
    end
  end

  assign RdWriteDataOut   = main_data_q;
  assign RdAddrOut        = main_addr_q;
  assign RdWriteEnableOut = main_en_q & {LANES{mv}};
  assign Occupancy        = {1'b0, mv} + {1'b0, sv};

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed scenarios on single- and dual-lane instances
// plus a randomized stream scored against a FIFO reference model.
module tb_mem_wb_pipe_reg;
  localparam int DW = 64;
  localparam int AW = 5;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Flush = 1'b0;

  // single-lane stimulus shared by the guarded and unguarded instances
  logic          a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic [AW-1:0] a_addr = '0;
  logic          a_en = 1'b0;
  logic          a_in_ready, a_out_valid, a_en_out;
  logic [DW-1:0] a_data_out;
  logic [AW-1:0] a_addr_out;
  logic [1:0]    a_occ;
  logic          g_in_ready, g_out_valid, g_en_out;
  logic [DW-1:0] g_data_out;
  logic [AW-1:0] g_addr_out;
  logic [1:0]    g_occ;

  // dual-lane instance
  logic            b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [2*DW-1:0] b_data = '0;
  logic [2*AW-1:0] b_addr = '0;
  logic [1:0]      b_en = '0;
  logic            b_in_ready, b_out_valid;
  logic [1:0]      b_en_out;
  logic [2*DW-1:0] b_data_out;
  logic [2*AW-1:0] b_addr_out;
  logic [1:0]      b_occ;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .LANES(1)) u_a (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .InValid(a_in_valid), .InReady(a_in_ready),
    .RdWriteDataIn(a_data), .RdAddrIn(a_addr), .RdWriteEnableIn(a_en),
    .OutValid(a_out_valid), .OutReady(a_out_ready),
    .RdWriteDataOut(a_data_out), .RdAddrOut(a_addr_out), .RdWriteEnableOut(a_en_out),
    .Occupancy(a_occ)
  );

  mem_wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .LANES(1), .ZERO_REG_GUARD(1'b0)) u_g (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .InValid(a_in_valid), .InReady(g_in_ready),
    .RdWriteDataIn(a_data), .RdAddrIn(a_addr), .RdWriteEnableIn(a_en),
    .OutValid(g_out_valid), .OutReady(a_out_ready),
    .RdWriteDataOut(g_data_out), .RdAddrOut(g_addr_out), .RdWriteEnableOut(g_en_out),
    .Occupancy(g_occ)
  );

  mem_wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .LANES(2)) u_b (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .InValid(b_in_valid), .InReady(b_in_ready),
    .RdWriteDataIn(b_data), .RdAddrIn(b_addr), .RdWriteEnableIn(b_en),
    .OutValid(b_out_valid), .OutReady(b_out_ready),
    .RdWriteDataOut(b_data_out), .RdAddrOut(b_addr_out), .RdWriteEnableOut(b_en_out),
    .Occupancy(b_occ)
  );

  // Expected stored enables for a 2-lane beat: x0 never written, and lane 0
  // yields to lane 1 when both really write the same register.
  function automatic logic [1:0] model_en(input logic [2*AW-1:0] addr, input logic [1:0] en);
    logic [AW-1:0] r0, r1;
    logic w0, w1;
    r0 = addr[AW-1:0];
    r1 = addr[2*AW-1:AW];
    w1 = en[1] && (r1 != 0);
    w0 = en[0] && (r0 != 0) && !(w1 && (r1 == r0));
    return {w1, w0};
  endfunction

  task automatic test_reset();
    Rst = 1'b1;
    @(negedge Clk);
    a_in_valid = 1'b1; a_addr = 5'd3; a_data = 64'h123; a_en = 1'b1; a_out_ready = 1'b0;
    @(negedge Clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rst_preload_valid got=%0d exp=1", a_out_valid); end
    #2 Rst = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_en_out !== 1'b0 || a_occ !== 2'd0)
      begin failures++; $display("FAIL rst_ctrl got valid=%0d en=%0d occ=%0d exp 0/0/0", a_out_valid, a_en_out, a_occ); end
    checks++; if (a_data_out !== '0 || a_addr_out !== '0)
      begin failures++; $display("FAIL rst_data got data=%h addr=%0d exp 0/0", a_data_out, a_addr_out); end
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || g_in_ready !== 1'b1)
      begin failures++; $display("FAIL rst_inready got a=%0d b=%0d g=%0d exp 1", a_in_ready, b_in_ready, g_in_ready); end
    checks++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || b_en_out !== 2'b00 || b_data_out !== '0)
      begin failures++; $display("FAIL rst_dual got valid=%0d occ=%0d en=%0d exp 0", b_out_valid, b_occ, b_en_out); end
  endtask

  task automatic test_single_beat();
    @(negedge Clk);
    Rst = 1'b1;
    a_in_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEAD; a_en = 1'b1; a_out_ready = 1'b1;
    @(negedge Clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_addr_out !== 5'd5 || a_data_out !== 64'hDEAD || a_en_out !== 1'b1)
      begin failures++; $display("FAIL single_beat got v=%0d addr=%0d data=%h en=%0d exp 1/5/dead/1", a_out_valid, a_addr_out, a_data_out, a_en_out); end
    checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL single_occ got=%0d exp=1", a_occ); end
    @(negedge Clk);
    checks++; if (a_out_valid !== 1'b0 || a_en_out !== 1'b0 || a_data_out !== 64'hDEAD)
      begin failures++; $display("FAIL single_drained got v=%0d en=%0d data=%h exp 0/0/dead", a_out_valid, a_en_out, a_data_out); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA; a_en = 1'b1;
    @(negedge Clk);
    a_addr = 5'd2; a_data = 64'hB;
    @(negedge Clk);
    a_addr = 5'd3; a_data = 64'hC;
    checks++; if (a_in_ready !== 1'b0 || a_occ !== 2'd2)
      begin failures++; $display("FAIL bp_full got rdy=%0d occ=%0d exp 0/2", a_in_ready, a_occ); end
    @(negedge Clk);
    checks++; if (a_data_out !== 64'hA || a_occ !== 2'd2)
      begin failures++; $display("FAIL bp_hold got data=%h occ=%0d exp a/2", a_data_out, a_occ); end
    a_out_ready = 1'b1;
    @(negedge Clk);
    checks++; if (a_data_out !== 64'hB || a_addr_out !== 5'd2 || a_out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_second got data=%h addr=%0d exp b/2", a_data_out, a_addr_out); end
    @(negedge Clk);
    a_in_valid = 1'b0;
    checks++; if (a_data_out !== 64'hC || a_addr_out !== 5'd3 || a_en_out !== 1'b1)
      begin failures++; $display("FAIL bp_third got data=%h addr=%0d exp c/3", a_data_out, a_addr_out); end
    @(negedge Clk);
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0)
      begin failures++; $display("FAIL bp_empty got v=%0d occ=%0d exp 0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_zero_guard();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_addr = 5'd0; a_data = 64'h55; a_en = 1'b1;
    @(negedge Clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_en_out !== 1'b0)
      begin failures++; $display("FAIL x0_guard got v=%0d en=%0d exp 1/0", a_out_valid, a_en_out); end
    checks++; if (g_out_valid !== 1'b1 || g_en_out !== 1'b1)
      begin failures++; $display("FAIL x0_noguard got v=%0d en=%0d exp 1/1", g_out_valid, g_en_out); end
    @(negedge Clk);
  endtask

  task automatic test_squash();
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_addr = {5'd7, 5'd7}; b_en = 2'b11; b_data = {64'h2, 64'h1};
    @(negedge Clk);
    b_addr = {5'd8, 5'd7};
    checks++; if (b_en_out !== 2'b10 || b_addr_out !== {5'd7, 5'd7})
      begin failures++; $display("FAIL squash_same got en=%b addr=%h exp 10/e7", b_en_out, b_addr_out); end
    @(negedge Clk);
    b_in_valid = 1'b0;
    checks++; if (b_en_out !== 2'b11 || b_addr_out !== {5'd8, 5'd7})
      begin failures++; $display("FAIL squash_diff got en=%b addr=%h exp 11/107", b_en_out, b_addr_out); end
    @(negedge Clk);
  endtask

  task automatic test_flush();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_addr = {5'd1, 5'd2}; b_en = 2'b11; b_data = {64'h11, 64'h22};
    @(negedge Clk);
    b_addr = {5'd3, 5'd4}; b_data = {64'h33, 64'h44};
    @(negedge Clk);
    checks++; if (b_occ !== 2'd2 || b_in_ready !== 1'b0)
      begin failures++; $display("FAIL flush_setup got occ=%0d rdy=%0d exp 2/0", b_occ, b_in_ready); end
    Flush = 1'b1; b_addr = {5'd9, 5'd9}; b_data = {64'h99, 64'h99};
    @(negedge Clk);
    Flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    checks++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || b_in_ready !== 1'b1 || b_en_out !== 2'b00)
      begin failures++; $display("FAIL flush_state got v=%0d occ=%0d rdy=%0d en=%b exp 0/0/1/00", b_out_valid, b_occ, b_in_ready, b_en_out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++; if (b_out_valid !== 1'b0 || b_en_out !== 2'b00)
        begin failures++; $display("FAIL flush_ghost cycle=%0d got v=%0d en=%b exp 0/00", k, b_out_valid, b_en_out); end
    end
  endtask

  task automatic test_streaming();
    logic [2*DW-1:0] q_data[$];
    logic [2*AW-1:0] q_addr[$];
    logic [1:0]      q_en[$];
    int sent = 0;
    int cyc = 0;
    logic prev_rdy;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    while ((sent < 100 || q_data.size() > 0) && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      checks++; if (b_occ !== 2'(q_data.size()))
        begin failures++; $display("FAIL stream_occ cyc=%0d got=%0d exp=%0d", cyc, b_occ, q_data.size()); end
      checks++; if (b_in_ready !== (q_data.size() < 2))
        begin failures++; $display("FAIL stream_inready cyc=%0d got=%0d exp=%0d", cyc, b_in_ready, q_data.size() < 2); end
      checks++; if (b_out_valid !== (q_data.size() > 0))
        begin failures++; $display("FAIL stream_outvalid cyc=%0d got=%0d exp=%0d", cyc, b_out_valid, q_data.size() > 0); end
      if (q_data.size() > 0) begin
        checks++; if (b_data_out !== q_data[0] || b_addr_out !== q_addr[0] || b_en_out !== q_en[0])
          begin failures++; $display("FAIL stream_beat cyc=%0d got data=%h addr=%h en=%b exp data=%h addr=%h en=%b",
                                     cyc, b_data_out, b_addr_out, b_en_out, q_data[0], q_addr[0], q_en[0]); end
      end else begin
        checks++; if (b_en_out !== 2'b00)
          begin failures++; $display("FAIL stream_idle_en cyc=%0d got=%b exp=00", cyc, b_en_out); end
      end
      prev_rdy = b_in_ready;
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (b_in_ready !== prev_rdy)
        begin failures++; $display("FAIL stream_comb_path cyc=%0d got=%0d exp=%0d", cyc, b_in_ready, prev_rdy); end
      if (b_out_valid && b_out_ready && q_data.size() > 0) begin
        void'(q_data.pop_front()); void'(q_addr.pop_front()); void'(q_en.pop_front());
      end
      if (sent < 100 && ($urandom_range(0, 3) != 0)) begin
        b_in_valid = 1'b1;
        b_data = {$urandom, $urandom, $urandom, $urandom};
        b_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        b_en = 2'($urandom_range(0, 3));
      end else begin
        b_in_valid = 1'b0;
      end
      if (b_in_valid && b_in_ready) begin
        q_data.push_back(b_data);
        q_addr.push_back(b_addr);
        q_en.push_back(model_en(b_addr, b_en));
        sent++;
      end
    end
    b_in_valid = 1'b0;
    checks++; if (cyc >= 3000)
      begin failures++; $display("FAIL stream_timeout sent=%0d pending=%0d exp all drained", sent, q_data.size()); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_zero_guard();
    test_squash();
    test_flush();
    test_streaming();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM->WB pipeline boundary for the Balotelli core, replacing the fixed always-enabled register set.
- Carries LANES writeback lanes (data, rd address, rd write-enable) with a valid/ready handshake and a 2-entry skid buffer, so WB back-pressure does not combinationally reach MEM.
- Adds synchronous flush, x0 write suppression, same-destination squash across lanes, and an occupancy output.

Parameters:
DATA_W, 64, width of one lane's rd write data
ADDR_W, 5, width of one lane's rd address
LANES, 1, number of writeback lanes (1..4); lane 0 is oldest
ZERO_REG_GUARD, 1, 1 = clear a lane's enable at capture when its addr==0
SAME_DEST_SQUASH, 1, 1 = at capture, clear an older lane's enable when a younger enabled lane has the same nonzero addr

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-low reset
Flush  in  1  synchronous flush, highest priority after reset
InValid  in  1  MEM-side beat valid
InReady  out  1  stage can accept a beat
RdWriteDataIn  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
RdAddrIn  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
RdWriteEnableIn  in  LANES  per-lane write enable
OutValid  out  1  WB-side beat valid
OutReady  in  1  WB consumes the beat
RdWriteDataOut  out  LANES*DATA_W  main-entry data
RdAddrOut  out  LANES*ADDR_W  main-entry addresses
RdWriteEnableOut  out  LANES  main-entry enables AND OutValid
Occupancy  out  2  number of held beats, 0..2

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit (mv, sv) plus LANES x {data, addr, en}.
- Rst low (asynchronous): mv=sv=0; all data, addr and en registers = 0. Consequences: OutValid=0, RdWriteDataOut=0, RdAddrOut=0, RdWriteEnableOut=0, Occupancy=0, InReady=1.
- Rst asserted mid-transfer: all held beats are lost.
- Handshake signals:
  - InReady = !sv, purely from a register; no combinational path from OutReady.
  - OutValid = mv.
  - accept = InValid & InReady; drain = OutValid & OutReady.
- Capture filtering (applied before the enable is stored):
  - en_i' = en_i & !(ZERO_REG_GUARD & addr_i==0).
  - If SAME_DEST_SQUASH: en_i' = 0 when some j>i has en_j'=1 and addr_j==addr_i.
  - Data and addr are stored unmodified.
- FSM on {mv,sv}:
  - EMPTY(00): accept -> BUSY, main<=in.
  - BUSY(10): accept & drain -> BUSY, main<=in. accept & !drain -> FULL, skid<=in. drain only -> EMPTY. neither -> BUSY, hold.
  - FULL(11): InReady=0. drain -> BUSY, main<=skid. else -> FULL, hold.
  - State 01 is unreachable.
- Latency: a beat accepted at edge N appears on the outputs after edge N, i.e. 1 cycle. Throughput is 1 beat/cycle while OutReady=1.
- Ordering: strictly FIFO; skid contents never bypass main.
- Flush=1 at an edge: mv=sv=0 and all stored en=0. Any same-cycle accept is discarded. Data/addr are don't-care but must not cause writes.
  - Flush with Rst high and no accept: next state EMPTY, InReady=1 in the following cycle.
- When !mv, outputs hold their last values, but RdWriteEnableOut=0 regardless.
- Occupancy = mv + sv.

Test Plan:
- Reset / single beat: Rst low mid-cycle, then release; InValid=1, RdAddrIn=5, RdWriteDataIn=0xDEAD, en=1, OutReady=1 -> outputs 0 and InReady=1 during reset; next cycle OutValid=1, RdAddrOut=5, RdWriteDataOut=0xDEAD, RdWriteEnableOut=1; Occupancy=1.
- Back-pressure: OutReady=0, send beats A, B, C back-to-back -> A in main, B in skid, InReady=0 from the cycle after B is accepted, C held upstream, Occupancy=2. Then OutReady=1 -> A, B, C drain in order, one per cycle.
- x0 guard: RdAddrIn=0, en=1 -> RdWriteEnableOut=0 with OutValid=1. Repeat with ZERO_REG_GUARD=0 -> enable=1.
- Dual-lane squash: LANES=2, lane0 addr=7, lane1 addr=7, both en=1 -> RdWriteEnableOut=2'b10. With lane1 addr=8 -> 2'b11.
- Flush: in state FULL assert Flush with InValid=1 -> next cycle OutValid=0, Occupancy=0, InReady=1, RdWriteEnableOut=0, and the flushed input beat never appears.
- Streaming: 100 random beats with random OutReady -> scoreboard shows no loss, no duplication, FIFO order preserved; InReady never depends combinationally on OutReady.
